// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access aligner: FSM states, legal
// transfer sizes, beat sizing and load-result extension.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  function automatic logic legal_size(input logic [3:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
  endfunction

  // Largest power of two that fits in what is left and keeps the beat aligned.
  function automatic logic [3:0] beat_size(input logic [2:0] cur_addr,
                                           input logic [3:0] remaining);
    if (cur_addr == 3'd0 && remaining >= SZ_D) return SZ_D;
    if (cur_addr[1:0] == 2'd0 && remaining >= SZ_W) return SZ_W;
    if (cur_addr[0] == 1'b0 && remaining >= SZ_H) return SZ_H;
    return SZ_B;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] data,
                                         input logic [3:0]  size,
                                         input logic        sgn);
    case (size)
      SZ_B:    return {{56{sgn & data[7]}},  data[7:0]};
      SZ_H:    return {{48{sgn & data[15]}}, data[15:0]};
      SZ_W:    return {{32{sgn & data[31]}}, data[31:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_beat_planner.sv
// Combinational beat planner: from the request base address and progress so
// far, produces the next aligned beat and the progress after it.
module mem_beat_planner
  import mem_access_pkg::*;
(
  input  logic [63:0] addr_q,
  input  logic [3:0]  offset,
  input  logic [3:0]  remaining,
  output logic [63:0] cur_addr,
  output logic [3:0]  beat_sz,
  output logic [3:0]  next_offset,
  output logic [3:0]  next_remaining
);

  always_comb begin
    cur_addr       = addr_q + {60'd0, offset};
    beat_sz        = beat_size(cur_addr[2:0], remaining);
    next_offset    = offset + beat_sz;
    next_remaining = remaining - beat_sz;
  end

endmodule

// File: rtl/mem_access_aligner.sv
// Splits arbitrary-alignment loads/stores into naturally aligned memory beats,
// assembles load data and returns one extended response per request.
module mem_access_aligner
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [3:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  offset_q, offset_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [63:0] asm_q, asm_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;

  logic [63:0] cur_addr;
  logic [3:0]  beat_sz, next_offset, next_remaining;
  logic [64:0] req_end;
  logic        req_bad;
  logic [63:0] lane_data;
  logic        wr_beat;
  logic [2:0]  dst;

  mem_beat_planner u_planner (
    .addr_q         (addr_q),
    .offset         (offset_q),
    .remaining      (remaining_q),
    .cur_addr       (cur_addr),
    .beat_sz        (beat_sz),
    .next_offset    (next_offset),
    .next_remaining (next_remaining)
  );

  // 65-bit end address so requests near the top of the address space cannot wrap.
  assign req_end   = {1'b0, req_addr} + {61'd0, req_size};
  assign req_bad   = !legal_size(req_size) || (req_end > 65'(MEM_SIZE));
  assign lane_data = wdata_q >> {offset_q[2:0], 3'b000};

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    addr_d         = addr_q;
    size_d         = size_q;
    signed_d       = signed_q;
    wdata_d        = wdata_q;
    offset_d       = offset_q;
    remaining_d    = remaining_q;
    asm_d          = asm_q;
    resp_valid_d   = 1'b0;
    resp_error_d   = 1'b0;
    resp_rdata_d   = '0;
    mem_address    = '0;
    mem_xfer_size  = SZ_D;
    mem_write_data = '0;
    mem_read_enable = 1'b0;
    wr_beat        = 1'b0;
    dst            = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          size_d      = req_size;
          signed_d    = req_signed;
          wdata_d     = req_wdata;
          offset_d    = '0;
          remaining_d = req_size;
          asm_d       = '0;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d = BEAT;
          end
        end
      end
      BEAT: begin
        mem_address   = cur_addr;
        mem_xfer_size = beat_sz;
        if (write_q) begin
          wr_beat = 1'b1;
          for (int k = 0; k < 8; k++) begin
            if (4'(k) < beat_sz) mem_write_data[8*k +: 8] = lane_data[8*k +: 8];
          end
        end else begin
          mem_read_enable = 1'b1;
          for (int k = 0; k < 8; k++) begin
            dst = offset_q[2:0] + 3'(k);
            if (4'(k) < beat_sz) asm_d[{dst, 3'b000} +: 8] = mem_read_data[8*k +: 8];
          end
        end
        offset_d    = next_offset;
        remaining_d = next_remaining;
        if (next_remaining == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (!write_q) resp_rdata_d = extend(asm_d, size_q, signed_q);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      offset_q     <= '0;
      remaining_q  <= '0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      offset_q     <= offset_d;
      remaining_q  <= remaining_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Gating with reset_n keeps the reset edge from committing a store beat.
  assign mem_write_enable = wr_beat & reset_n;
  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;

endmodule
